rot_req_queue: RTL and testbench

- Upstream request stage for the 4-bit combinational rotate-right shifter.
- Accepts rotate requests (data word, 4-bit amount, direction) over a valid/ready handshake and buffers them in a FIFO.
- Translates the head request into the shifter's 2-bit select and presents it with the data word to the shifter.
- Registers the shifter's combinational result into a valid/ready output stage for downstream consumers.

---
 rtl/rot_req_queue_pkg.sv | 15 +
 rtl/rot_fifo.sv | 84 ++++++++
 rtl/rot_req_queue.sv | 93 +++++++++
 tb/tb_rot_req_queue.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_req_queue_pkg.sv
// Shared constants and the (amount, direction) -> shifter select mapping for the rotate datapath.
package rot_req_queue_pkg;

    localparam int ROT_W = 4;
    localparam int SEL_W = 2;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // The shifter only rotates right, so a left rotate by k becomes a right rotate by (4 - k) mod 4.
    function automatic logic [SEL_W-1:0] rot_sel_f(input logic [3:0] amt, input logic dir);
        rot_sel_f = (dir == DIR_LEFT) ? SEL_W'(4'd0 - amt) : SEL_W'(amt);
    endfunction

endpackage

// File: rtl/rot_fifo.sv
// Generic synchronous FIFO with a combinational head view, flush, and an occupancy count.
module rot_fifo
    import rot_req_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 6,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] head_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0]    mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic [DEPTH-1:0] wr_en;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == FULL_CNT);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push_ok && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    // Storage needs no reset: the head view is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_reg[i] <= push_data;
            end
        end
    end

    assign head_data = empty ? '0 : mem_reg[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/rot_req_queue.sv
// Request queue in front of the 4-bit rotate-right shifter: buffers {data, sel} entries and
// registers the shifter's result into a valid/ready output stage.
module rot_req_queue
    import rot_req_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [3:0]       in_amt,
    input  logic             in_dir,
    input  logic             flush,
    output logic [WIDTH-1:0] rot_data,
    output logic [SEL_W-1:0] rot_sel,
    input  logic [WIDTH-1:0] rot_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             overflow
);

    localparam int          EW       = WIDTH + SEL_W;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [EW-1:0]    push_entry;
    logic [EW-1:0]    head_entry;
    logic [AW:0]      fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             overflow_reg;

    assign in_ready   = (fifo_count != FULL_CNT);
    assign push       = in_valid && !fifo_full && !flush;
    assign pop        = !fifo_empty && (!out_valid_reg || out_ready) && !flush;
    // Only the shifter select is stored; amount and direction are folded in at push time.
    assign push_entry = {in_data, rot_sel_f(in_amt, in_dir)};

    rot_fifo #(
        .DEPTH (DEPTH),
        .DW    (EW),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {rot_data, rot_sel} = head_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (pop) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= rot_result;
        end else if (out_ready && out_valid_reg) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Sticky until reset; flush deliberately leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow_reg <= 1'b1;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_rot_req_queue.sv
// Randomized and directed checks of rot_req_queue against a queue-based rotate reference model.
module tb_rot_req_queue;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [3:0] in_amt;
    logic       in_dir;
    logic       flush;
    logic [3:0] rot_data;
    logic [1:0] rot_sel;
    logic [3:0] rot_result;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       overflow;

    int vectors    = 0;
    int miscompares = 0;

    logic [3:0] exp_q[$];
    logic [3:0] obs_q[$];

    always #5 clk = ~clk;

    rot_req_queue #(.DEPTH(DEPTH), .WIDTH(4), .AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amt     (in_amt),
        .in_dir     (in_dir),
        .flush      (flush),
        .rot_data   (rot_data),
        .rot_sel    (rot_sel),
        .rot_result (rot_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .overflow   (overflow)
    );

    // Stand-in for the combinational rotate-right shifter.
    assign rot_result = 4'({rot_data, rot_data} >> rot_sel);

    // Reference: rotate the word by amt (mod 4) in the requested direction.
    function automatic logic [3:0] ref_rot(input logic [3:0] d, input logic [3:0] amt, input logic dir);
        int v;
        int k;
        int r;
        v = int'(d);
        k = int'(amt) % 4;
        if (dir) r = (v << k) | (v >> (4 - k));
        else     r = (v >> k) | (v << (4 - k));
        return 4'(r & 15);
    endfunction

    // Advance one clock, updating the model from the handshakes about to happen at this edge.
    task automatic tick();
        if (in_valid && in_ready && !flush) exp_q.push_back(ref_rot(in_data, in_amt, in_dir));
        if (out_valid && out_ready) obs_q.push_back(out_data);
        if (flush) begin
            while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 0; in_data = 0; in_amt = 0; in_dir = 0; flush = 0; out_ready = 0;
        #1;
        vectors++;
        if ({in_ready, out_valid, out_data, overflow, rot_data, rot_sel} !== {1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 2'h0}) begin
            miscompares++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h overflow=%b rot_data=%h rot_sel=%0d, required 1 0 0 0 0 0",
                     in_ready, out_valid, out_data, overflow, rot_data, rot_sel);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete(); obs_q.delete();
        $display("reset: outputs idle");
    endtask

    task automatic test_select();
        logic [3:0] t_amt [4] = '{4'd1, 4'd1, 4'd5, 4'd4};
        logic       t_dir [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] t_sel [4] = '{2'd1, 2'd3, 2'd1, 2'd0};
        logic [3:0] t_out [4] = '{4'b1101, 4'b0111, 4'b1101, 4'b1011};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 4'b1011; in_amt = t_amt[i]; in_dir = t_dir[i];
            tick();
            in_valid = 1'b0;
            vectors++;
            if (rot_sel !== t_sel[i] || rot_data !== 4'b1011) begin
                miscompares++;
                $display("FAIL select[%0d]: rot_sel=%0d rot_data=%b, required %0d 1011", i, rot_sel, rot_data, t_sel[i]);
            end
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== t_out[i]) begin
                miscompares++;
                $display("FAIL result[%0d]: out_valid=%b out_data=%b, required 1 %b", i, out_valid, out_data, t_out[i]);
            end
            $display("select: amt=%0d dir=%0b sel=%0d out=%b", t_amt[i], t_dir[i], rot_sel, out_data);
            tick();
        end
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_idle: overflow=%b, required 0", overflow);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_backpressure();
        int acc = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = 4'($urandom); in_amt = 4'($urandom); in_dir = 1'($urandom);
            vectors++;
            if (in_ready !== (i < 5)) begin
                miscompares++;
                $display("FAIL bp_in_ready[%0d]: in_ready=%b, required %b", i, in_ready, (i < 5));
            end
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        vectors++;
        if (acc != 5 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_accept: accepted=%0d overflow=%b, required 5 1", acc, overflow);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            vectors++;
            if (out_valid !== (j < 5)) begin
                miscompares++;
                $display("FAIL bp_release[%0d]: out_valid=%b, required %b", j, out_valid, (j < 5));
            end
            tick();
        end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL bp_count: results=%0d, required %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            vectors++;
            if (obs_q[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL bp_data[%0d]: out_data=%h, required %h", k, obs_q[k], exp_q[k]);
            end
        end
        $display("backpressure: accepted %0d, drained %0d", acc, obs_q.size());
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 8); in_data = 4'($urandom); in_amt = 4'($urandom); in_dir = 1'($urandom);
            tick();
            vectors++;
            if (out_valid !== (i >= 1 && i <= 8)) begin
                miscompares++;
                $display("FAIL stream_valid[%0d]: out_valid=%b, required %b", i, out_valid, (i >= 1 && i <= 8));
            end
        end
        in_valid = 1'b0;
        drain();
        vectors++;
        if (obs_q.size() != 8 || exp_q.size() != 8) begin
            miscompares++;
            $display("FAIL stream_count: results=%0d, required 8", obs_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            vectors++;
            if (obs_q[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL stream_data[%0d]: out_data=%h, required %h", k, obs_q[k], exp_q[k]);
            end
        end
        $display("streaming: %0d results", obs_q.size());
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_simul();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 4'($urandom); in_amt = 4'($urandom); in_dir = 1'($urandom);
            tick();
        end
        in_data = 4'($urandom); out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL simul_hold: in_ready=%b out_valid=%b, required 1 1", in_ready, out_valid);
        end
        in_data = 4'($urandom);
        tick();
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_full: in_ready=%b, required 0", in_ready);
        end
        drain();
        vectors++;
        if (obs_q.size() != 6 || exp_q.size() != 6) begin
            miscompares++;
            $display("FAIL simul_count: results=%0d, required 6", obs_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            vectors++;
            if (obs_q[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL simul_data[%0d]: out_data=%h, required %h", k, obs_q[k], exp_q[k]);
            end
        end
        $display("simultaneous push/pop: %0d results in order", obs_q.size());
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_flush();
        logic ovf_before;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 4'($urandom); in_amt = 4'($urandom); in_dir = 1'($urandom);
            tick();
        end
        ovf_before = overflow;
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || overflow !== ovf_before || rot_data !== 4'h0 || rot_sel !== 2'd0) begin
            miscompares++;
            $display("FAIL flush: out_valid=%b in_ready=%b overflow=%b rot_data=%h rot_sel=%0d, required 0 1 %b 0 0",
                     out_valid, in_ready, overflow, rot_data, rot_sel, ovf_before);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 4'($urandom); in_amt = 4'($urandom); in_dir = 1'($urandom);
            tick();
        end
        drain();
        vectors++;
        if (obs_q.size() != 2 || exp_q.size() != 2) begin
            miscompares++;
            $display("FAIL flush_after: results=%0d, required 2", obs_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            vectors++;
            if (obs_q[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL flush_data[%0d]: out_data=%h, required %h", k, obs_q[k], exp_q[k]);
            end
        end
        $display("flush: dropped queue, %0d later results", obs_q.size());
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 4'hA; in_amt = 4'd0; in_dir = 1'b0;
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({in_ready, out_valid, out_data, overflow, rot_data, rot_sel} !== {1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 2'h0}) begin
            miscompares++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b out_data=%h overflow=%b rot_data=%h rot_sel=%0d, required 1 0 0 0 0 0",
                     in_ready, out_valid, out_data, overflow, rot_data, rot_sel);
        end
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        $display("async reset: outputs cleared before clock edge");
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 4'($urandom); in_amt = 4'($urandom); in_dir = 1'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 59) == 0);
            tick();
        end
        flush = 1'b0;
        drain();
        vectors++;
        if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL random_count: results=%0d, required %0d", obs_q.size(), exp_q.size());
        end
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
            vectors++;
            if (obs_q[k] !== exp_q[k]) begin
                miscompares++;
                $display("FAIL random_data[%0d]: out_data=%h, required %h", k, obs_q[k], exp_q[k]);
            end
        end
        $display("random: %0d results checked", obs_q.size());
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_select();
        test_backpressure();
        test_streaming();
        test_simul();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
